// File: rtl/wb_cmd_pkg.sv
// Shared types and constants for the Wishbone command master and its users.
package wb_cmd_pkg;

  // Controller states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_GAP  = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  // Response codes
  localparam logic [1:0] RSP_OK        = 2'b00;
  localparam logic [1:0] RSP_TIMEOUT   = 2'b01;
  localparam logic [1:0] RSP_POLL_FAIL = 2'b10;

  // GPIO block register map
  localparam logic [31:0] IO_L  = 32'h300F_FFF0;
  localparam logic [31:0] IO_H  = 32'h300F_FFF4;
  localparam logic [31:0] OEB_L = 32'h300F_FFEC;
  localparam logic [31:0] OEB_H = 32'h300F_FFE8;

  // True when the masked bits of dat equal the masked bits of val
  function automatic logic poll_match(input logic [31:0] dat,
                                      input logic [31:0] mask,
                                      input logic [31:0] val);
    return ((dat ^ val) & mask) == 32'd0;
  endfunction

endpackage

// File: rtl/wb_cmd_master_if.sv
// Wishbone master-side bus bundle; the master drives the request side,
// the slave returns ack and read data.
interface wb_cmd_master_if;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic        wbm_ack_i;
  logic [31:0] wbm_dat_i;

  modport master (
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    input  wbm_ack_i, wbm_dat_i
  );

  modport slave (
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    output wbm_ack_i, wbm_dat_i
  );
endinterface

// File: rtl/wb_cmd_master.sv
// Command-driven Wishbone master: runs one single-beat transfer per command,
// optionally re-reading (poll mode) until a masked compare matches, and
// returns exactly one response per accepted command.
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_IDLE | cmd_ready high, waiting for a command
// ST_BUS  | cyc/stb high, waiting for ack or timeout terminal count
// ST_GAP  | one idle cycle between poll reads (cyc low)
// ST_RESP | rsp_valid high, fields frozen until rsp_ready
module wb_cmd_master
  import wb_cmd_pkg::*;
#(
  parameter int TIMEOUT  = 64,   // cycles a bus cycle may stay open without ack
  parameter int POLL_MAX = 16    // read attempts in poll mode, 1..255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,

  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic        cmd_poll,
  input  logic [31:0] cmd_adr,
  input  logic [31:0] cmd_dat,
  input  logic [3:0]  cmd_sel,
  input  logic [31:0] cmd_mask,
  input  logic [31:0] cmd_val,

  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_dat,
  output logic [1:0]  rsp_code,
  output logic [7:0]  rsp_polls,

  wb_cmd_master_if.master wbm
);

  // Timeout is a down-counter loaded with TIMEOUT-1 on BUS entry; reaching
  // zero without ack ends the cycle after exactly TIMEOUT bus cycles.
  localparam int            TW         = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TO_LOAD    = TW'(TIMEOUT - 1);
  localparam logic [7:0]    POLL_LIMIT = 8'(POLL_MAX);

  state_t        state;
  logic          cyc_q;
  logic          we_q;
  logic          poll_q;
  logic [3:0]    sel_q;
  logic [31:0]   adr_q;
  logic [31:0]   dat_q;
  logic [31:0]   mask_q;
  logic [31:0]   val_q;
  logic [7:0]    attempts;
  logic [TW-1:0] to_cnt;

  logic [7:0]    att_inc;
  logic          hit;

  // Attempt count after the current ack, saturating at 255
  assign att_inc = (attempts == 8'hFF) ? 8'hFF : attempts + 8'd1;
  assign hit     = poll_match(wbm.wbm_dat_i, mask_q, val_q);

  // stb always mirrors cyc: single-beat transfers only
  assign wbm.wbm_cyc_o = cyc_q;
  assign wbm.wbm_stb_o = cyc_q;
  assign wbm.wbm_we_o  = we_q;
  assign wbm.wbm_sel_o = sel_q;
  assign wbm.wbm_adr_o = adr_q;
  assign wbm.wbm_dat_o = dat_q;

  // Controller FSM with all outputs and counters registered
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state     <= ST_IDLE;
      cmd_ready <= 1'b0;
      cyc_q     <= 1'b0;
      we_q      <= 1'b0;
      poll_q    <= 1'b0;
      sel_q     <= 4'h0;
      adr_q     <= 32'h0;
      dat_q     <= 32'h0;
      mask_q    <= 32'h0;
      val_q     <= 32'h0;
      attempts  <= 8'h0;
      to_cnt    <= '0;
      rsp_valid <= 1'b0;
      rsp_dat   <= 32'h0;
      rsp_code  <= RSP_OK;
      rsp_polls <= 8'h0;
    end else begin
      case (state)
        ST_IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            we_q      <= cmd_we;
            poll_q    <= cmd_poll & ~cmd_we;
            sel_q     <= cmd_sel;
            adr_q     <= cmd_adr;
            dat_q     <= cmd_dat;
            mask_q    <= cmd_mask;
            val_q     <= cmd_val;
            attempts  <= 8'h0;
            to_cnt    <= TO_LOAD;
            rsp_dat   <= 32'h0;
            cyc_q     <= 1'b1;
            state     <= ST_BUS;
          end
        end

        ST_BUS: begin
          // ack takes priority over a simultaneous timeout terminal count
          if (wbm.wbm_ack_i) begin
            cyc_q    <= 1'b0;
            attempts <= att_inc;
            if (!we_q) rsp_dat <= wbm.wbm_dat_i;
            if (!poll_q || hit) begin
              rsp_code  <= RSP_OK;
              rsp_polls <= att_inc;
              rsp_valid <= 1'b1;
              state     <= ST_RESP;
            end else if (att_inc == POLL_LIMIT) begin
              rsp_code  <= RSP_POLL_FAIL;
              rsp_polls <= att_inc;
              rsp_valid <= 1'b1;
              state     <= ST_RESP;
            end else begin
              state <= ST_GAP;
            end
          end else if (to_cnt == '0) begin
            cyc_q     <= 1'b0;
            rsp_dat   <= 32'h0;
            rsp_code  <= RSP_TIMEOUT;
            rsp_polls <= attempts;
            rsp_valid <= 1'b1;
            state     <= ST_RESP;
          end else begin
            to_cnt <= to_cnt - 1'b1;
          end
        end

        ST_GAP: begin
          to_cnt <= TO_LOAD;
          cyc_q  <= 1'b1;
          state  <= ST_BUS;
        end

        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end

        default: begin
          cyc_q     <= 1'b0;
          cmd_ready <= 1'b0;
          rsp_valid <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_cmd_master.sv
// Self-checking bench for wb_cmd_master with a behavioural GPIO slave and a
// transaction-level reference model of the expected responses.
module tb_wb_cmd_master;
  import wb_cmd_pkg::*;

  localparam int TIMEOUT  = 8;
  localparam int POLL_MAX = 4;
  localparam logic [31:0] UNMAPPED = 32'h3000_0100;

  logic        clk;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_we, cmd_poll;
  logic [31:0] cmd_adr, cmd_dat, cmd_mask, cmd_val;
  logic [3:0]  cmd_sel;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_dat;
  logic [1:0]  rsp_code;
  logic [7:0]  rsp_polls;

  int vectors = 0;
  int miscompares = 0;

  wb_cmd_master_if bus();

  wb_cmd_master #(.TIMEOUT(TIMEOUT), .POLL_MAX(POLL_MAX)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_we   (cmd_we),
    .cmd_poll (cmd_poll),
    .cmd_adr  (cmd_adr),
    .cmd_dat  (cmd_dat),
    .cmd_sel  (cmd_sel),
    .cmd_mask (cmd_mask),
    .cmd_val  (cmd_val),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_dat  (rsp_dat),
    .rsp_code (rsp_code),
    .rsp_polls(rsp_polls),
    .wbm      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- GPIO slave ----------------
  logic        s_ack;
  logic [31:0] s_dat;
  logic [63:0] io_out, oeb, io_in;
  logic        s_en;
  int          s_lat;
  int          s_cnt;

  assign bus.wbm_ack_i = s_ack;
  assign bus.wbm_dat_i = s_dat;

  function automatic logic is_mapped(input logic [31:0] a);
    return (a == IO_L) || (a == IO_H) || (a == OEB_L) || (a == OEB_H);
  endfunction

  function automatic logic [31:0] bmask(input logic [3:0] s);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[i*8 +: 8] = {8{s[i]}};
    return m;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      s_ack <= 1'b0; s_dat <= 32'h0; s_cnt <= 0; io_out <= 64'h0; oeb <= 64'h0;
    end else begin
      s_ack <= 1'b0;
      if (bus.wbm_cyc_o && bus.wbm_stb_o && !s_ack && s_en && is_mapped(bus.wbm_adr_o)) begin
        if (s_cnt >= s_lat) begin
          s_ack <= 1'b1;
          s_cnt <= 0;
          if (bus.wbm_we_o) begin
            case (bus.wbm_adr_o)
              IO_L:  io_out[31:0]  <= (io_out[31:0]  & ~bmask(bus.wbm_sel_o)) | (bus.wbm_dat_o & bmask(bus.wbm_sel_o));
              IO_H:  io_out[63:32] <= (io_out[63:32] & ~bmask(bus.wbm_sel_o)) | (bus.wbm_dat_o & bmask(bus.wbm_sel_o));
              OEB_L: oeb[31:0]     <= (oeb[31:0]     & ~bmask(bus.wbm_sel_o)) | (bus.wbm_dat_o & bmask(bus.wbm_sel_o));
              default: oeb[63:32]  <= (oeb[63:32]    & ~bmask(bus.wbm_sel_o)) | (bus.wbm_dat_o & bmask(bus.wbm_sel_o));
            endcase
          end else begin
            case (bus.wbm_adr_o)
              IO_L:    s_dat <= io_in[31:0];
              IO_H:    s_dat <= io_in[63:32];
              OEB_L:   s_dat <= oeb[31:0];
              default: s_dat <= oeb[63:32];
            endcase
          end
        end else begin
          s_cnt <= s_cnt + 1;
        end
      end else begin
        s_cnt <= 0;
      end
    end
  end

  // ---------------- bus monitor ----------------
  int   cyc_hi, pulses, gaps;
  logic cyc_d = 1'b0;

  always @(negedge clk) begin
    vectors++;
    if (bus.wbm_stb_o !== bus.wbm_cyc_o) begin
      miscompares++;
      $display("FAIL stb_eq_cyc stb=%b cyc=%b t=%0t", bus.wbm_stb_o, bus.wbm_cyc_o, $time);
    end
    if (bus.wbm_cyc_o === 1'b1) cyc_hi++;
    if (bus.wbm_cyc_o === 1'b1 && !cyc_d) pulses++;
    if (bus.wbm_cyc_o === 1'b0 && pulses > 0 && !rsp_valid && !cmd_ready && !rst) gaps++;
    cyc_d = bus.wbm_cyc_o;
  end

  // ---------------- reference model state ----------------
  logic [63:0] m_io_out, m_oeb;
  logic        acc_cyc;

  function automatic logic [31:0] model_read(input logic [31:0] a);
    case (a)
      IO_L:    return io_in[31:0];
      IO_H:    return io_in[63:32];
      OEB_L:   return m_oeb[31:0];
      OEB_H:   return m_oeb[63:32];
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] m;
    m = bmask(s);
    case (a)
      IO_L:  m_io_out[31:0]  = (m_io_out[31:0]  & ~m) | (d & m);
      IO_H:  m_io_out[63:32] = (m_io_out[63:32] & ~m) | (d & m);
      OEB_L: m_oeb[31:0]     = (m_oeb[31:0]     & ~m) | (d & m);
      OEB_H: m_oeb[63:32]    = (m_oeb[63:32]    & ~m) | (d & m);
      default: ;
    endcase
  endtask

  // Issue one command, wait for its response, optionally hold rsp_ready low
  // for 'hold' cycles while checking the response stays frozen.
  task automatic do_cmd(input logic we, input logic poll, input logic [31:0] adr,
                        input logic [31:0] dat, input logic [3:0] sel,
                        input logic [31:0] mask, input logic [31:0] val, input int hold,
                        output logic [31:0] r_dat, output logic [1:0] r_code,
                        output logic [7:0] r_polls);
    int n;
    int p0;
    r_dat = 32'hX; r_code = 2'bXX; r_polls = 8'hXX;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = we; cmd_poll = poll; cmd_adr = adr; cmd_dat = dat;
    cmd_sel = sel; cmd_mask = mask; cmd_val = val;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    vectors++;
    if (cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL accept_wait cmd_ready=%b required 1 within 50 cycles", cmd_ready);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    acc_cyc = bus.wbm_cyc_o;
    cyc_hi = 0; pulses = 0; gaps = 0;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    vectors++;
    if (rsp_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL rsp_wait rsp_valid=%b required 1 within 200 cycles", rsp_valid);
      return;
    end
    r_dat = rsp_dat; r_code = rsp_code; r_polls = rsp_polls;
    p0 = pulses;
    for (int i = 0; i < hold; i++) begin
      cmd_valid = 1'b1; cmd_adr = UNMAPPED; cmd_we = 1'b0; cmd_poll = 1'b0;
      @(negedge clk);
      vectors++;
      if ({rsp_valid, rsp_dat, rsp_code, rsp_polls} !== {1'b1, r_dat, r_code, r_polls}) begin
        miscompares++;
        $display("FAIL rsp_stable cyc%0d got v=%b dat=%h code=%b polls=%0d required v=1 dat=%h code=%b polls=%0d",
                 i, rsp_valid, rsp_dat, rsp_code, rsp_polls, r_dat, r_code, r_polls);
      end
      vectors++;
      if ({cmd_ready, bus.wbm_cyc_o} !== 2'b00 || pulses != p0) begin
        miscompares++;
        $display("FAIL bp_quiet cyc%0d got cmd_ready=%b cyc=%b new_pulses=%0d required 0 0 0",
                 i, cmd_ready, bus.wbm_cyc_o, pulses - p0);
      end
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if ({cmd_ready, bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_we_o, rsp_valid} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl got rdy=%b cyc=%b stb=%b we=%b rv=%b required all 0",
               cmd_ready, bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_we_o, rsp_valid);
    end
    vectors++;
    if ({bus.wbm_sel_o, bus.wbm_adr_o, bus.wbm_dat_o, rsp_dat, rsp_code, rsp_polls} !== 110'b0) begin
      miscompares++;
      $display("FAIL reset_data got sel=%h adr=%h dat=%h rdat=%h code=%b polls=%0d required 0",
               bus.wbm_sel_o, bus.wbm_adr_o, bus.wbm_dat_o, rsp_dat, rsp_code, rsp_polls);
    end
    rst = 1'b0;
    m_io_out = 64'h0; m_oeb = 64'h0;
    #1;
    vectors++;
    if (cmd_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL ready_before_edge got %b required 0", cmd_ready);
    end
    @(negedge clk);
    vectors++;
    if (cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL ready_after_edge got %b required 1", cmd_ready);
    end
  endtask

  task automatic test_write_gpio();
    logic [31:0] d; logic [1:0] c; logic [7:0] p;
    s_en = 1'b1; s_lat = 0;
    do_cmd(1'b1, 1'b0, IO_L, 32'h0000_00A5, 4'hF, 32'h0, 32'h0, 0, d, c, p);
    model_write(IO_L, 32'h0000_00A5, 4'hF);
    vectors++;
    if (acc_cyc !== 1'b1) begin
      miscompares++; $display("FAIL wr_cyc_after_accept got %b required 1", acc_cyc);
    end
    vectors++;
    if (io_out[7:0] !== 8'hA5) begin
      miscompares++; $display("FAIL wr_io_out got %h required a5", io_out[7:0]);
    end
    vectors++;
    if ({c, p, d} !== {RSP_OK, 8'd1, 32'h0}) begin
      miscompares++; $display("FAIL wr_rsp got code=%b polls=%0d dat=%h required 00 1 0", c, p, d);
    end
  endtask

  task automatic test_timeout();
    logic [31:0] d; logic [1:0] c; logic [7:0] p;
    s_en = 1'b0;
    do_cmd(1'b0, 1'b0, IO_H, 32'h0, 4'hF, 32'h0, 32'h0, 0, d, c, p);
    s_en = 1'b1;
    vectors++;
    if (cyc_hi != TIMEOUT || pulses != 1) begin
      miscompares++; $display("FAIL to_cyc_len got hi=%0d pulses=%0d required %0d 1", cyc_hi, pulses, TIMEOUT);
    end
    vectors++;
    if ({c, d, p} !== {RSP_TIMEOUT, 32'h0, 8'd0}) begin
      miscompares++; $display("FAIL to_rsp got code=%b dat=%h polls=%0d required 01 0 0", c, d, p);
    end
  endtask

  task automatic test_poll_success();
    logic [31:0] d; logic [1:0] c; logic [7:0] p;
    s_lat = 1; io_in = 64'h0; pulses = 0;
    fork
      do_cmd(1'b0, 1'b1, IO_L, 32'h0, 4'hF, 32'h1, 32'h1, 0, d, c, p);
      begin
        for (int i = 0; i < 300; i++) begin
          @(posedge clk); #1;
          if (pulses == 3 && bus.wbm_cyc_o === 1'b0) begin io_in[0] = 1'b1; break; end
        end
      end
    join
    vectors++;
    if (gaps != 3 || pulses != 4) begin
      miscompares++; $display("FAIL poll_gaps got gaps=%0d pulses=%0d required 3 4", gaps, pulses);
    end
    vectors++;
    if ({c, p, d} !== {RSP_OK, 8'd4, 32'h1}) begin
      miscompares++; $display("FAIL poll_ok_rsp got code=%b polls=%0d dat=%h required 00 4 1", c, p, d);
    end
  endtask

  task automatic test_poll_fail();
    logic [31:0] d; logic [1:0] c; logic [7:0] p;
    s_lat = 0;
    io_in = {$urandom, $urandom & 32'hFFFF_FFFE};
    do_cmd(1'b0, 1'b1, IO_L, 32'h0, 4'hF, 32'h1, 32'h1, 0, d, c, p);
    vectors++;
    if (pulses != POLL_MAX || gaps != POLL_MAX - 1) begin
      miscompares++; $display("FAIL pf_pulses got pulses=%0d gaps=%0d required %0d %0d", pulses, gaps, POLL_MAX, POLL_MAX - 1);
    end
    vectors++;
    if ({c, p, d} !== {RSP_POLL_FAIL, 8'(POLL_MAX), io_in[31:0]}) begin
      miscompares++; $display("FAIL pf_rsp got code=%b polls=%0d dat=%h required 10 %0d %h", c, p, d, POLL_MAX, io_in[31:0]);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] d; logic [1:0] c; logic [7:0] p;
    s_lat = 2;
    do_cmd(1'b1, 1'b0, OEB_L, 32'hDEAD_BEEF, 4'hF, 32'h0, 32'h0, 0, d, c, p);
    model_write(OEB_L, 32'hDEAD_BEEF, 4'hF);
    do_cmd(1'b0, 1'b0, OEB_L, 32'h0, 4'hF, 32'h0, 32'h0, 10, d, c, p);
    vectors++;
    if ({c, p, d} !== {RSP_OK, 8'd1, m_oeb[31:0]}) begin
      miscompares++; $display("FAIL bp_rsp got code=%b polls=%0d dat=%h required 00 1 %h", c, p, d, m_oeb[31:0]);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d; logic [1:0] c; logic [7:0] p;
    int n;
    int rv_seen;
    s_en = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_poll = 1'b0; cmd_adr = IO_L; cmd_sel = 4'hF;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    #2;
    vectors++;
    if (bus.wbm_cyc_o !== 1'b1) begin
      miscompares++; $display("FAIL rm_cyc_open got %b required 1", bus.wbm_cyc_o);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if ({bus.wbm_cyc_o, bus.wbm_stb_o, cmd_ready} !== 3'b000) begin
      miscompares++; $display("FAIL rm_async_drop got cyc=%b stb=%b rdy=%b required 000",
                              bus.wbm_cyc_o, bus.wbm_stb_o, cmd_ready);
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    m_io_out = 64'h0; m_oeb = 64'h0;
    s_en = 1'b1; s_lat = 1;
    rv_seen = 0;
    repeat (6) begin @(negedge clk); if (rsp_valid !== 1'b0) rv_seen++; end
    vectors++;
    if (rv_seen != 0) begin
      miscompares++; $display("FAIL rm_no_rsp got %0d rsp_valid cycles required 0", rv_seen);
    end
    do_cmd(1'b1, 1'b0, OEB_H, 32'h1234_5678, 4'hF, 32'h0, 32'h0, 0, d, c, p);
    model_write(OEB_H, 32'h1234_5678, 4'hF);
    vectors++;
    if ({c, p} !== {RSP_OK, 8'd1}) begin
      miscompares++; $display("FAIL rm_next_wr got code=%b polls=%0d required 00 1", c, p);
    end
    do_cmd(1'b0, 1'b0, OEB_H, 32'h0, 4'hF, 32'h0, 32'h0, 0, d, c, p);
    vectors++;
    if ({c, d} !== {RSP_OK, m_oeb[63:32]}) begin
      miscompares++; $display("FAIL rm_next_rd got code=%b dat=%h required 00 %h", c, d, m_oeb[63:32]);
    end
  endtask

  task automatic test_random();
    logic [31:0] adrs [5];
    logic [31:0] d, a, wd, mk, vl, rv, e_dat;
    logic [1:0]  c, e_code;
    logic [7:0]  p, e_polls;
    logic [3:0]  sl;
    logic        we, pl;
    int          e_pulses, pick;
    adrs[0] = IO_L; adrs[1] = IO_H; adrs[2] = OEB_L; adrs[3] = OEB_H; adrs[4] = UNMAPPED;
    for (int k = 0; k < 40; k++) begin
      s_lat = $urandom_range(0, 3);
      io_in = {$urandom, $urandom};
      pick  = $urandom_range(0, 8);
      a     = adrs[(pick > 4) ? pick - 4 : pick];
      we    = 1'($urandom_range(0, 1));
      pl    = !we && ($urandom_range(0, 2) != 0);
      wd    = $urandom;
      sl    = 4'($urandom_range(1, 15));
      mk    = $urandom;
      rv    = model_read(a);
      vl    = ($urandom_range(0, 1) == 1) ? (rv ^ ($urandom & ~mk)) : $urandom;
      if (!is_mapped(a)) begin
        e_code = RSP_TIMEOUT; e_dat = 32'h0; e_polls = 8'd0; e_pulses = 1;
      end else if (we) begin
        e_code = RSP_OK; e_dat = 32'h0; e_polls = 8'd1; e_pulses = 1;
      end else if (!pl || ((rv ^ vl) & mk) == 32'h0) begin
        e_code = RSP_OK; e_dat = rv; e_polls = 8'd1; e_pulses = 1;
      end else begin
        e_code = RSP_POLL_FAIL; e_dat = rv; e_polls = 8'(POLL_MAX); e_pulses = POLL_MAX;
      end
      do_cmd(we, pl, a, wd, sl, mk, vl, $urandom_range(0, 3), d, c, p);
      if (we) model_write(a, wd, sl);
      vectors++;
      if ({c, d, p} !== {e_code, e_dat, e_polls} || pulses != e_pulses) begin
        miscompares++;
        $display("FAIL rand%0d adr=%h we=%b poll=%b got code=%b dat=%h polls=%0d pulses=%0d required %b %h %0d %0d",
                 k, a, we, pl, c, d, p, pulses, e_code, e_dat, e_polls, e_pulses);
      end
      vectors++;
      if ({io_out, oeb} !== {m_io_out, m_oeb}) begin
        miscompares++;
        $display("FAIL rand%0d_regs got io_out=%h oeb=%h required %h %h", k, io_out, oeb, m_io_out, m_oeb);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_we = 1'b0; cmd_poll = 1'b0; cmd_adr = 32'h0; cmd_dat = 32'h0;
    cmd_sel = 4'h0; cmd_mask = 32'h0; cmd_val = 32'h0; rsp_ready = 1'b0;
    s_en = 1'b1; s_lat = 0; io_in = 64'h0;
    m_io_out = 64'h0; m_oeb = 64'h0; acc_cyc = 1'b0;
    cyc_hi = 0; pulses = 0; gaps = 0;
    test_reset();
    test_write_gpio();
    test_timeout();
    test_poll_success();
    test_poll_fail();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog simulation did not finish by %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/wb_cmd_master.md
WB_CMD_MASTER -- requirements
Module: wb_cmd_master

Interface
REQ-001 SHALL have parameter TIMEOUT, default 64: max cycles a Wishbone cycle stays open without ack.
REQ-002 SHALL have parameter POLL_MAX, default 16: max read attempts in poll mode, range 1-255.
REQ-003 SHALL have clock wb_clk_i; reset wb_rst_i, asynchronous, active-high.
REQ-004 Command port signals SHALL be:
- cmd_valid in 1: command present
- cmd_ready out 1: command accepted on valid&&ready
- cmd_we in 1: write=1, read=0
- cmd_poll in 1: repeat reads until match; ignored when cmd_we=1
- cmd_adr in 32: byte address
- cmd_dat in 32: write data
- cmd_sel in 4: byte enables
- cmd_mask in 32: poll compare mask
- cmd_val in 32: poll compare value
REQ-005 Response port signals SHALL be:
- rsp_valid out 1: response present
- rsp_ready in 1: response consumed on valid&&ready
- rsp_dat out 32: last read data; 0 for writes
- rsp_code out 2: 00 OK, 01 TIMEOUT, 10 POLL_FAIL
- rsp_polls out 8: read attempts issued
REQ-006 Wishbone master port signals SHALL be:
- wbm_cyc_o out 1
- wbm_stb_o out 1
- wbm_we_o out 1
- wbm_sel_o out 4
- wbm_adr_o out 32
- wbm_dat_o out 32
- wbm_ack_i in 1
- wbm_dat_i in 32

Function
REQ-007 FSM states SHALL be IDLE, BUS, GAP, RESP; all outputs registered.
REQ-008 cmd_ready SHALL be 1 only in IDLE; on accept, latch all cmd fields, clear attempt counter, go to BUS.
REQ-009 In BUS, cyc and stb SHALL both be 1, with we/sel/adr/dat driven from latched fields. cyc rises on the first edge after accept.
REQ-010 When ack_i=1 is sampled in BUS, cyc and stb SHALL drop at that same edge; wbm_dat_i is captured if reading; the attempt counter increments with saturation at 255.
REQ-011 A write or non-poll read SHALL go BUS->RESP on ack with code 00.
REQ-012 Poll read on ack:
- (dat_i & mask)==(val & mask): RESP, code 00
- else if attempts==POLL_MAX: RESP, code 10
- else: GAP for exactly 1 cycle (cyc=0), then BUS again
REQ-013 The timeout counter SHALL clear on entry to BUS and count each BUS cycle without ack. On reaching TIMEOUT: drop cyc/stb, RESP, code 01, rsp_dat=0.
REQ-014 If ack and the timeout terminal count occur in the same cycle, ack SHALL win.
REQ-015 In RESP, rsp_valid=1 with rsp_dat/rsp_code/rsp_polls held stable until rsp_ready=1; then IDLE next edge. cmd_ready=0 throughout RESP.
REQ-016 A response SHALL be issued for every accepted command, exactly once; no command is accepted while rsp_valid=1.
REQ-017 cyc SHALL never be 1 outside BUS; stb==cyc always.
REQ-018 The master SHALL issue no bursts and no retries except poll mode; ack_i sampled outside BUS is ignored.

Reset
REQ-019 Reset SHALL take effect asynchronously: state=IDLE, cyc/stb/we=0, sel/adr/dat=0, rsp_valid=0, rsp_*=0, counters=0, cmd_ready=0 during reset.
REQ-020 cmd_ready SHALL become 1 on the first edge after reset release.
REQ-021 Reset mid-cycle SHALL drop cyc/stb immediately with no response issued; the in-flight command is lost.

Structure
REQ-022 A shared package wb_cmd_pkg SHALL hold:
- the state enum
- rsp_code constants RSP_OK/RSP_TIMEOUT/RSP_POLL_FAIL
- GPIO register address constants: 0x300FFFF0 IO_L, 0x300FFFF4 IO_H, 0x300FFFEC OEB_L, 0x300FFFE8 OEB_H
REQ-023 The block SHALL be a single module with counters inline; no sub-module.

Verification
REQ-024 Write with GPIO slave attached: adr 0x300FFFF0, dat 0x000000A5, sel F. Required: cyc high 1 cycle after accept; slave io_out[7:0]=A5; rsp_code 00; rsp_polls 1.
REQ-025 Read with no slave (ack tied 0), TIMEOUT=8. Required: cyc high exactly 8 cycles; rsp_code 01; rsp_dat 0.
REQ-026 Poll with mask 0x1, val 0x1 at 0x300FFFF0; io_in[0] set before the 4th read. Required: 3 GAP cycles observed; rsp_code 00; rsp_polls 4.
REQ-027 Poll with POLL_MAX=4 and io_in[0] stuck 0. Required: rsp_code 10; rsp_polls 4; exactly 4 cyc pulses.
REQ-028 Backpressure: hold rsp_ready=0 for 10 cycles. Required: rsp fields stable; cmd_ready 0; no new cyc.
REQ-029 Reset mid-cycle: assert wb_rst_i while cyc=1. Required: cyc=0 without a clock edge; rsp_valid stays 0; next command completes normally.
